// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t     : FSM encoding used by serial_carry_adder (IDLE, RUN, DONE).
//   clog2_min1  : width of a counter that indexes 0..w-1, never narrower than 1 bit.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2_min1(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_carry_cell.sv
// One bit position of a carry chain, built as the LUT + MUXCY + XORCY trio.
// Purely combinational.
//   a, b : operand bits
//   ci   : carry into this bit
//   o    : sum bit, ci ^ (a ^ b)
//   co   : carry out; the propagate bit selects ci, otherwise a (== b) generates
module serial_carry_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic o,
    output logic co
);

    logic li;

    assign li = a ^ b;
    assign o  = ci ^ li;
    assign co = li ? ci : a;

endmodule

// File: rtl/serial_carry_adder.sv
// Bit-serial adder: {COUT,S} = A + B + CIN, one bit per clock, LSB first.
// Operands are captured in parallel when START is accepted (IDLE or DONE),
// processed over WIDTH RUN cycles, and the result is held from the DONE
// pulse until the next accepted START.
//   C         : clock, rising edge
//   R         : synchronous active-high reset
//   START     : request, sampled only in IDLE or DONE
//   A, B, CIN : operands and carry-in, captured on the accepting edge
//   BUSY      : high while in RUN
//   DONE      : one-cycle pulse, S/COUT valid
//   S, COUT   : registered sum and carry-out
//   state_dbg : current FSM state
//
// Handshake: START is a level request; an accepting edge is any rising edge
// where START=1 and the FSM is in IDLE or DONE. START in RUN is ignored.
module serial_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic                     C,
    input  logic                     R,
    input  logic                     START,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic                     CIN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [WIDTH-1:0]         S,
    output logic                     COUT,
    output serial_arith_pkg::state_t state_dbg
);

    import serial_arith_pkg::*;

    localparam int            CW       = clog2_min1(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_shifted;
    logic [WIDTH-1:0] s_q;
    logic             ci;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             bit_o;
    logic             bit_co;
    logic             accept;
    logic             last_bit;

    serial_carry_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (ci),
        .o  (bit_o),
        .co (bit_co)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit i sits at i.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign s_shifted = bit_o;
        end else begin : g_sum_wn
            assign s_shifted = {bit_o, s_sh[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = START && ((state == IDLE) || (state == serial_arith_pkg::DONE));
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_next = serial_arith_pkg::DONE;
                end
            end
            serial_arith_pkg::DONE: begin
                state_next = START ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, carry, counter, result registers
    always_ff @(posedge C) begin
        if (R) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            ci     <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            ci   <= CIN;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s_sh <= s_shifted;
            ci   <= bit_co;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                s_q    <= s_shifted;
                cout_q <= bit_co;
            end
        end
    end

    assign BUSY      = (state == RUN);
    assign DONE      = (state == serial_arith_pkg::DONE);
    assign S         = s_q;
    assign COUT      = cout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_carry_adder.sv
// Directed bench for serial_carry_adder: an 8-bit instance for latency,
// ripple, START-in-RUN, back-to-back and mid-run reset cases, plus a
// 1-bit instance walked through all A/B/CIN combinations.
module tb_serial_carry_adder;

    // ---------------- clock / reset ----------------
    logic c;
    logic r;

    initial c = 1'b0;
    always #5 c = ~c;

    // ---------------- 8-bit DUT ----------------
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        busy;
    logic        done_o;
    logic [7:0]  s;
    logic        cout;
    serial_arith_pkg::state_t state_dbg;

    serial_carry_adder #(.WIDTH(8)) dut (
        .C         (c),
        .R         (r),
        .START     (start),
        .A         (a),
        .B         (b),
        .CIN       (cin),
        .BUSY      (busy),
        .DONE      (done_o),
        .S         (s),
        .COUT      (cout),
        .state_dbg (state_dbg)
    );

    // ---------------- 1-bit DUT ----------------
    logic        start1;
    logic [0:0]  a1;
    logic [0:0]  b1;
    logic        cin1;
    logic        busy1;
    logic        done1;
    logic [0:0]  s1;
    logic        cout1;
    serial_arith_pkg::state_t state_dbg1;

    serial_carry_adder #(.WIDTH(1)) dut1 (
        .C         (c),
        .R         (r),
        .START     (start1),
        .A         (a1),
        .B         (b1),
        .CIN       (cin1),
        .BUSY      (busy1),
        .DONE      (done1),
        .S         (s1),
        .COUT      (cout1),
        .state_dbg (state_dbg1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs driven after this return land on the next edge,
    // outputs read after it are stable (1 time unit past the edge).
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // Accept a START, wait (bounded) for DONE, check latency and result.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv);
        int n;
        logic [8:0] exp;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        exp = exp_q.pop_front();
        check({tag, "_latency"}, n, 8);
        check({tag, "_s"}, s, exp[7:0]);
        check({tag, "_cout"}, cout, exp[8]);
        tick();
        check({tag, "_done_one_cycle"}, done_o, 1'b0);
        check({tag, "_s_held"}, s, exp[7:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int dones;
        logic busy_low;

        r = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        r = 1'b0;

        // Reset state
        check("rst_state", state_dbg, serial_arith_pkg::IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_s", s, 8'h00);
        check("rst_cout", cout, 1'b0);
        tick();

        // 1: 0x5A + 0x33, BUSY for exactly 8 cycles
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_busy", busy, 1'b1);
            check("t1_no_done", done_o, 1'b0);
            tick();
        end
        check("t1_done", done_o, 1'b1);
        check("t1_busy_off", busy, 1'b0);
        check("t1_s", s, 8'h8D);
        check("t1_cout", cout, 1'b0);
        tick();
        check("t1_idle", state_dbg, serial_arith_pkg::IDLE);
        check("t1_s_held", s, 8'h8D);

        // 2: full ripples
        run_op("t2_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("t2_ff_00_c", 8'hFF, 8'h00, 1'b1);
        run_op("t2_a5_5a_c", 8'hA5, 8'h5A, 1'b1);
        run_op("t2_80_80_c", 8'h80, 8'h80, 1'b1);

        // 3: START held high and operands changed during RUN
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (i >= 2 && i <= 5) begin
                a = 8'hFF ^ 8'(i); b = 8'(i * 37); cin = 1'b1;
            end
            if (i == 8) start = 1'b0;
            check("t3_busy", busy, 1'b1);
            tick();
        end
        check("t3_done", done_o, 1'b1);
        check("t3_s", s, 8'h8D);
        check("t3_cout", cout, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_o) dones++;
            tick();
        end
        check("t3_one_done", dones, 1);

        // 4: back-to-back
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        check("t4_first_latency", n, 8);
        check("t4_first_s", s, 8'h8D);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        busy_low = 1'b0;
        while (!done_o && n < 20) begin
            if (!busy) busy_low = 1'b1;
            tick();
            n++;
        end
        check("t4_second_gap", n, 9);
        check("t4_busy_continuous", busy_low, 1'b0);
        check("t4_second_s", s, 8'h30);
        check("t4_second_cout", cout, 1'b0);
        tick();

        // 5: reset in RUN cycle 4
        a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t5_busy_before", busy, 1'b1);
        r = 1'b1;
        tick();
        r = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done_o, 1'b0);
        check("t5_s", s, 8'h00);
        check("t5_cout", cout, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_o) dones++;
            tick();
        end
        check("t5_no_done", dones, 0);
        run_op("t5_after", 8'h5A, 8'h33, 1'b0);

        // 6: WIDTH=1 exhaustive
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp1;
            a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = 1'(k);
            exp1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("t6_busy", busy1, 1'b1);
            tick();
            check("t6_done", done1, 1'b1);
            check("t6_sum", {cout1, s1}, exp1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_carry_adder.md
Name: serial_carry_adder

Overview:
Bit-serial adder built around the carry-chain cell pair. Each cycle it forms the propagate bit LI = A[i]^B[i] and feeds it, with the registered carry CI, into a sum XOR: O = CI^LI. The next carry is selected MUXCY-style: LI ? CI : A[i].
It is a small-area sequential alternative to a full-width carry chain, used where latency can be traded for LUT/carry resources. Operands are loaded in parallel, processed LSB-first over WIDTH cycles, and presented as a parallel result with a done pulse.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- C  input  1  clock; all state updates on rising edge.
- R  input  1  reset, synchronous, active-high.
- START  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- CIN  input  1  carry-in; captured on the accepting edge.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; S and COUT are valid.
- S  output  WIDTH  sum; held from DONE until the next accepted START.
- COUT  output  1  carry-out of the MSB; held like S.

Behaviour:
- Reset:
  - Applied on the edge where R=1, overriding everything, including mid-operation.
  - After reset: state=IDLE, BUSY=0, DONE=0, S=0, COUT=0; shift registers, carry register and bit counter all 0.
  - An aborted operation produces no DONE.
- States: IDLE, RUN, DONE.
- IDLE:
  - START=1 at an edge: load a_sh<=A, b_sh<=B, ci<=CIN, cnt<=0; go to RUN.
  - START=0: stay in IDLE.
- RUN, on each edge:
  - li = a_sh[0]^b_sh[0].
  - o = ci^li.
  - ci <= li ? ci : a_sh[0].
  - s_sh <= {o, s_sh[WIDTH-1:1]} (MSB-in, so after WIDTH shifts bit i is in position i).
  - a_sh and b_sh shift right by 1.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: S<=final s_sh, COUT<=final ci; go to DONE.
  - START is ignored in RUN and has no side effects.
- DONE:
  - DONE=1 for exactly this cycle.
  - START=1: accepted exactly as in IDLE, going straight to RUN (back-to-back operation).
  - START=0: go to IDLE.
- Latency:
  - START is sampled at edge k; DONE is high during the cycle after edge k+WIDTH.
  - Throughput is one operation per WIDTH+1 cycles.
- Output timing:
  - BUSY is registered and equals (state==RUN).
  - DONE equals (state==DONE).
  - S and COUT change only on the RUN→DONE edge or on reset.
- Arithmetic:
  - {COUT,S} = A + B + CIN, modulo 2^(WIDTH+1).
  - No overflow flag.
- Counter:
  - cnt width is clog2(WIDTH), minimum 1 bit.
  - WIDTH=1: a single RUN cycle.
  - cnt is never compared past WIDTH-1, so there is no wrap hazard.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a cnt-width function clog2_min1(WIDTH).
- One natural sub-module, serial_carry_cell:
  - purely combinational; inputs a, b, ci; outputs o and co;
  - co = (a^b) ? ci : a.
- The top holds the FSM, shift registers, counter and output registers.

Test Plan:
1. WIDTH=8, A=0x5A, B=0x33, CIN=0, START pulse → BUSY high 8 cycles; DONE 8 cycles after the START edge; S=0x8D, COUT=0.
2. A=0xFF, B=0x01, CIN=0 → S=0x00, COUT=1. A=0xFF, B=0x00, CIN=1 → S=0x00, COUT=1 (full carry ripple).
3. START held high plus operand changes on cycles 2–5 of RUN → result unaffected (0x5A+0x33 still gives 0x8D); exactly one DONE.
4. Back-to-back: START high in the DONE cycle with A=0x10, B=0x20 → S=0x8D visible in the first DONE; next DONE exactly 9 cycles later with S=0x30; BUSY never low between the two.
5. R=1 at RUN cycle 4 → the next cycle shows BUSY=0, DONE=0, S=0, COUT=0; no DONE follows; a new START gives the correct result.
6. WIDTH=1 build: all 8 combinations of A, B, CIN → DONE 1 cycle after START; {COUT,S} = A+B+CIN.
